// File: rtl/opfetch_pkg.sv
// Shared constants for the operand fetch sequencer: FSM encoding, job modes
// and the default number of bank slots written per load sequence.
package opfetch_pkg;

  // FSM state encoding
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StKick    = 3'd1;
  localparam logic [2:0] StLoad    = 3'd2;
  localparam logic [2:0] StAccept  = 3'd3;
  localparam logic [2:0] StIssueLo = 3'd4;
  localparam logic [2:0] StIssueHi = 3'd5;
  localparam logic [2:0] StFin     = 3'd6;

  // Job modes, also driven straight onto the bank Core1 select
  localparam logic [1:0] MODE_MIXED = 2'd0;
  localparam logic [1:0] MODE_A     = 2'd1;
  localparam logic [1:0] MODE_B     = 2'd2;
  localparam logic [1:0] MODE_ILL   = 2'd3;

  localparam int unsigned NUM_SLOTS_DEF = 3;

  // Single-operand modes only need Core1 on the LSB beat; Core2 takes both beats.
  function automatic logic core1_needed(input logic [1:0] mode, input logic hi_beat);
    return (mode == MODE_MIXED) || !hi_beat;
  endfunction

endpackage

// File: rtl/opfetch_hs_join.sv
// Dual valid/ready join for one operand beat. Valids launch one cycle after the
// beat starts (bank read latency); each core's valid drops on its own accept and
// the beat completes once every needed core has accepted.
module opfetch_hs_join (
  input  logic clk_i,
  input  logic rst_i,
  input  logic beat_active_i,
  input  logic need1_i,
  input  logic need2_i,
  input  logic core1_ready_i,
  input  logic core2_ready_i,
  output logic core1_valid_o,
  output logic core2_valid_o,
  output logic beat_done_o
);

  logic arm_q, arm_d;
  logic acc1_q, acc1_d;
  logic acc2_q, acc2_d;
  logic done1, done2;

  // Handshake outputs and per-core accept tracking
  always_comb begin
    core1_valid_o = arm_q & need1_i & ~acc1_q;
    core2_valid_o = arm_q & need2_i & ~acc2_q;
    done1         = ~need1_i | acc1_q | (core1_valid_o & core1_ready_i);
    done2         = ~need2_i | acc2_q | (core2_valid_o & core2_ready_i);
    beat_done_o   = arm_q & done1 & done2;
    // Clearing arm on completion gives the next beat its own 1-cycle launch delay.
    arm_d         = beat_active_i & ~beat_done_o;
    acc1_d        = arm_d & (acc1_q | (core1_valid_o & core1_ready_i));
    acc2_d        = arm_d & (acc2_q | (core2_valid_o & core2_ready_i));
  end

  // Join state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arm_q  <= 1'b0;
      acc1_q <= 1'b0;
      acc2_q <= 1'b0;
    end else begin
      arm_q  <= arm_d;
      acc1_q <= acc1_d;
      acc2_q <= acc2_d;
    end
  end

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: kicks the bank load, counts the load beats, then
// turns multiply jobs into LSB/MSB bank read beats toward Core1/Core2.
// Optional start-to-done cycle counter enabled by OPFETCH_PERF_CNT_EN.
module operand_fetch_ctrl
  import opfetch_pkg::*;
#(
  parameter int unsigned DATA      = 256,
  parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int unsigned ADDR_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              wr_reg,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [1:0]        job_mode,
  input  logic [ADDR_W-1:0] job_addr1,
  input  logic [ADDR_W-1:0] job_addr2,
  input  logic [ADDR_W-1:0] job_addr_c2,
  input  logic              job_last,
  output logic [ADDR_W-1:0] addr_reg_a_1,
  output logic [ADDR_W-1:0] addr_reg_a_2,
  output logic [ADDR_W-1:0] addr_reg_b,
  output logic [1:0]        data_a_b_core1,
  output logic              msb_core1,
  output logic              mul_msb,
  output logic              core1_valid,
  input  logic              core1_ready,
  output logic              core2_valid,
  input  logic              core2_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       perf_cycles
);

  localparam int unsigned CntW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CntW-1:0] LastSlot = CntW'(NUM_SLOTS - 1);

  // The operand datapath lives in the bank; only the half-split must be well formed.
  if ((DATA % 2) != 0) begin : g_data_odd
  end

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] a1_q, a1_d;
  logic [ADDR_W-1:0] a2_q, a2_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic              last_q, last_d;
  logic              beat_active, need1, beat_done;

  // Next-state logic for the sequencer and latched job descriptor
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    mode_d  = mode_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    b_d     = b_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StKick;
          err_d   = 1'b0;
        end
      end
      StKick: begin
        state_d = StLoad;
        cnt_d   = '0;
      end
      StLoad: begin
        // Load cannot stall: a missing beat is flagged but the count runs on.
        if (!load_valid) err_d = 1'b1;
        if (cnt_q == LastSlot) begin
          cnt_d   = '0;
          state_d = StAccept;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAccept: begin
        if (job_valid) begin
          if (job_mode == MODE_ILL) begin
            err_d   = 1'b1;
            state_d = job_last ? StFin : StAccept;
          end else begin
            mode_d  = job_mode;
            a1_d    = job_addr1;
            a2_d    = job_addr2;
            b_d     = job_addr_c2;
            last_d  = job_last;
            state_d = StIssueLo;
          end
        end
      end
      StIssueLo: begin
        if (beat_done) state_d = StIssueHi;
      end
      StIssueHi: begin
        if (beat_done) state_d = last_q ? StFin : StAccept;
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mode_q  <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      b_q     <= b_d;
      last_q  <= last_d;
    end
  end

  // State-decoded control outputs
  always_comb begin
    wr_reg         = (state_q == StKick);
    load_ready     = (state_q == StLoad);
    job_ready      = (state_q == StAccept);
    done           = (state_q == StFin);
    busy           = (state_q != StIdle);
    msb_core1      = (state_q == StIssueHi);
    mul_msb        = (state_q == StIssueHi);
    beat_active    = (state_q == StIssueLo) || (state_q == StIssueHi);
    need1          = core1_needed(mode_q, state_q == StIssueHi);
    addr_reg_a_1   = a1_q;
    addr_reg_a_2   = a2_q;
    addr_reg_b     = b_q;
    data_a_b_core1 = mode_q;
    err            = err_q;
  end

  opfetch_hs_join u_hs_join (
    .clk_i         (clk),
    .rst_i         (rst),
    .beat_active_i (beat_active),
    .need1_i       (need1),
    .need2_i       (1'b1),
    .core1_ready_i (core1_ready),
    .core2_ready_i (core2_ready),
    .core1_valid_o (core1_valid),
    .core2_valid_o (core2_valid),
    .beat_done_o   (beat_done)
  );

`ifdef OPFETCH_PERF_CNT_EN
  logic [15:0] perf_q, perf_d;

  // Saturating busy-cycle counter, restarted by an accepted start
  always_comb begin
    perf_d = perf_q;
    if (state_q == StIdle) begin
      if (start) perf_d = '0;
    end else if (perf_q != 16'hFFFF) begin
      perf_d = perf_q + 16'd1;
    end
  end

  // Perf counter register
  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Directed bench for operand_fetch_ctrl. Inputs change and outputs are checked
// on the falling edge; the DUT samples on the rising edge.
module tb_operand_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, load_valid, job_valid, job_last;
  logic [1:0]  job_mode, job_addr1, job_addr2, job_addr_c2;
  logic        core1_ready, core2_ready;
  logic        load_ready, wr_reg, job_ready, msb_core1, mul_msb;
  logic [1:0]  addr_reg_a_1, addr_reg_a_2, addr_reg_b, data_a_b_core1;
  logic        core1_valid, core2_valid, busy, done, err;
  logic [15:0] perf_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  operand_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .wr_reg         (wr_reg),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_mode       (job_mode),
    .job_addr1      (job_addr1),
    .job_addr2      (job_addr2),
    .job_addr_c2    (job_addr_c2),
    .job_last       (job_last),
    .addr_reg_a_1   (addr_reg_a_1),
    .addr_reg_a_2   (addr_reg_a_2),
    .addr_reg_b     (addr_reg_b),
    .data_a_b_core1 (data_a_b_core1),
    .msb_core1      (msb_core1),
    .mul_msb        (mul_msb),
    .core1_valid    (core1_valid),
    .core1_ready    (core1_ready),
    .core2_valid    (core2_valid),
    .core2_ready    (core2_ready),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .perf_cycles    (perf_cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // All control/handshake outputs low, as in IDLE or right after reset
  task automatic chk_quiet(input string tag);
    check_eq({tag, ".busy"}, 32'(busy), 0);
    check_eq({tag, ".wr_reg"}, 32'(wr_reg), 0);
    check_eq({tag, ".load_ready"}, 32'(load_ready), 0);
    check_eq({tag, ".job_ready"}, 32'(job_ready), 0);
    check_eq({tag, ".c1v"}, 32'(core1_valid), 0);
    check_eq({tag, ".c2v"}, 32'(core2_valid), 0);
    check_eq({tag, ".done"}, 32'(done), 0);
    check_eq({tag, ".msb"}, 32'({msb_core1, mul_msb}), 0);
  endtask

  // From IDLE: start, then three load beats with load_valid taken from lv[i].
  // Returns at the first ACCEPT cycle.
  task automatic run_load(input string tag, input logic [2:0] lv);
    start = 1'b1;
    tick();
    check_eq({tag, ".kick_wr_reg"}, 32'(wr_reg), 1);
    check_eq({tag, ".kick_busy"}, 32'(busy), 1);
    check_eq({tag, ".kick_load_ready"}, 32'(load_ready), 0);
    check_eq({tag, ".kick_err"}, 32'(err), 0);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("%s.load_ready%0d", tag, i), 32'(load_ready), 1);
      check_eq($sformatf("%s.load_wr_reg%0d", tag, i), 32'(wr_reg), 0);
      load_valid = lv[i];
    end
    tick();
    load_valid = 1'b1;
    check_eq({tag, ".acc_job_ready"}, 32'(job_ready), 1);
    check_eq({tag, ".acc_load_ready"}, 32'(load_ready), 0);
  endtask

  // Present one job for a single cycle while in ACCEPT
  task automatic issue_job(input logic [1:0] m, input logic [1:0] a1, input logic [1:0] a2,
                           input logic [1:0] c2, input logic last);
    job_valid   = 1'b1;
    job_mode    = m;
    job_addr1   = a1;
    job_addr2   = a2;
    job_addr_c2 = c2;
    job_last    = last;
    tick();
    job_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; load_valid = 1'b1; job_valid = 1'b0; job_last = 1'b0;
    job_mode = 2'd0; job_addr1 = 2'd0; job_addr2 = 2'd0; job_addr_c2 = 2'd0;
    core1_ready = 1'b1; core2_ready = 1'b1;
    tick();
    tick();
    chk_quiet("rst");
    check_eq("rst.err", 32'(err), 0);
    check_eq("rst.addr", 32'({addr_reg_a_1, addr_reg_a_2, addr_reg_b, data_a_b_core1}), 0);
    check_eq("rst.perf", 32'(perf_cycles), 0);
    rst = 1'b0;
    tick();

    // A: clean load, mixed job (1,2,0), last, both cores always ready
    run_load("A", 3'b111);
    check_eq("A.err", 32'(err), 0);
    issue_job(2'd0, 2'd1, 2'd2, 2'd0, 1'b1);
    check_eq("A.lo1_addr", 32'({addr_reg_a_1, addr_reg_a_2, addr_reg_b}), 32'b01_10_00);
    check_eq("A.lo1_sel", 32'(data_a_b_core1), 0);
    check_eq("A.lo1_msb", 32'({msb_core1, mul_msb}), 0);
    check_eq("A.lo1_valid", 32'({core1_valid, core2_valid}), 0);
    check_eq("A.lo1_job_ready", 32'(job_ready), 0);
    tick();
    check_eq("A.lo2_valid", 32'({core1_valid, core2_valid}), 32'b11);
    check_eq("A.lo2_msb", 32'({msb_core1, mul_msb}), 0);
    tick();
    check_eq("A.hi1_msb", 32'({msb_core1, mul_msb}), 32'b11);
    check_eq("A.hi1_valid", 32'({core1_valid, core2_valid}), 0);
    tick();
    check_eq("A.hi2_valid", 32'({core1_valid, core2_valid}), 32'b11);
    tick();
    check_eq("A.done", 32'(done), 1);
    check_eq("A.fin_valid", 32'({core1_valid, core2_valid}), 0);
    tick();
    check_eq("A.done_once", 32'(done), 0);
    check_eq("A.idle_busy", 32'(busy), 0);
`ifdef OPFETCH_PERF_CNT_EN
    check_eq("A.perf", 32'(perf_cycles), 10);
`else
    check_eq("A.perf", 32'(perf_cycles), 0);
`endif

    // B: underrun on beat 2, then A-only job with slow Core2, then B-only job
    run_load("B", 3'b101);
    check_eq("B.err_underrun", 32'(err), 1);
    core1_ready = 1'b1;
    core2_ready = 1'b0;
    issue_job(2'd1, 2'd3, 2'd1, 2'd2, 1'b0);
    check_eq("B.lo1_sel", 32'(data_a_b_core1), 1);
    check_eq("B.lo1_addr", 32'({addr_reg_a_1, addr_reg_a_2, addr_reg_b}), 32'b11_01_10);
    check_eq("B.lo1_valid", 32'({core1_valid, core2_valid}), 0);
    tick();
    check_eq("B.lo2_valid", 32'({core1_valid, core2_valid}), 32'b11);
    tick();
    check_eq("B.lo3_valid", 32'({core1_valid, core2_valid}), 32'b01);
    tick();
    check_eq("B.lo4_valid", 32'({core1_valid, core2_valid}), 32'b01);
    check_eq("B.lo4_addr", 32'({addr_reg_a_1, addr_reg_a_2, addr_reg_b}), 32'b11_01_10);
    check_eq("B.lo4_msb", 32'(msb_core1), 0);
    tick();
    check_eq("B.lo5_valid", 32'({core1_valid, core2_valid}), 32'b01);
    check_eq("B.lo5_addr", 32'({addr_reg_a_1, addr_reg_a_2, addr_reg_b}), 32'b11_01_10);
    core2_ready = 1'b1;
    tick();
    check_eq("B.hi1_msb", 32'({msb_core1, mul_msb}), 32'b11);
    check_eq("B.hi1_valid", 32'({core1_valid, core2_valid}), 0);
    tick();
    check_eq("B.hi2_valid", 32'({core1_valid, core2_valid}), 32'b01);
    tick();
    check_eq("B.back_accept", 32'(job_ready), 1);
    check_eq("B.no_done", 32'(done), 0);
    issue_job(2'd2, 2'd0, 2'd3, 2'd1, 1'b1);
    check_eq("B.j2_sel", 32'(data_a_b_core1), 2);
    check_eq("B.j2_addr", 32'({addr_reg_a_1, addr_reg_a_2, addr_reg_b}), 32'b00_11_01);
    tick();
    check_eq("B.j2_lo2_valid", 32'({core1_valid, core2_valid}), 32'b11);
    tick();
    tick();
    check_eq("B.j2_hi2_valid", 32'({core1_valid, core2_valid}), 32'b01);
    tick();
    check_eq("B.done", 32'(done), 1);
    check_eq("B.err_sticky", 32'(err), 1);
    tick();
    check_eq("B.idle_busy", 32'(busy), 0);
    check_eq("B.idle_err", 32'(err), 1);

    // C: start clears err (checked at KICK); illegal jobs consume without issue
    run_load("C", 3'b111);
    issue_job(2'd3, 2'd1, 2'd1, 2'd1, 1'b0);
    check_eq("C.ill_stay", 32'(job_ready), 1);
    check_eq("C.ill_err", 32'(err), 1);
    check_eq("C.ill_valid", 32'({core1_valid, core2_valid}), 0);
    issue_job(2'd3, 2'd2, 2'd2, 2'd2, 1'b1);
    check_eq("C.ill_done", 32'(done), 1);
    check_eq("C.ill_fin_valid", 32'({core1_valid, core2_valid}), 0);
    check_eq("C.ill_fin_err", 32'(err), 1);
    tick();
    check_eq("C.idle_busy", 32'(busy), 0);

    // D: reset while in ISSUE_HI
    run_load("D", 3'b111);
    issue_job(2'd0, 2'd1, 2'd1, 2'd1, 1'b1);
    tick();
    tick();
    check_eq("D.hi_msb", 32'(msb_core1), 1);
    rst = 1'b1;
    tick();
    chk_quiet("D.rst");
    check_eq("D.rst_err", 32'(err), 0);
    check_eq("D.rst_addr", 32'({addr_reg_a_1, addr_reg_a_2, addr_reg_b, data_a_b_core1}), 0);
    rst = 1'b0;
    tick();

    // E: fresh run after reset
    run_load("E", 3'b111);
    issue_job(2'd0, 2'd2, 2'd3, 2'd1, 1'b1);
    check_eq("E.addr", 32'({addr_reg_a_1, addr_reg_a_2, addr_reg_b}), 32'b10_11_01);
    tick();
    check_eq("E.lo2_valid", 32'({core1_valid, core2_valid}), 32'b11);
    tick();
    tick();
    check_eq("E.hi2_valid", 32'({core1_valid, core2_valid}), 32'b11);
    tick();
    check_eq("E.done", 32'(done), 1);
    check_eq("E.err", 32'(err), 0);
    tick();
    chk_quiet("E.idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
